// File: rtl/uart_rx_medidas.sv
// 8N1 receiver for the two-byte telemetry frame (food, water).
// Presents both bytes together with a one-cycle frame strobe.
module uart_rx_medidas #(
    parameter int BAUD_DIV   = 104,
    parameter int GAP_CYCLES = 2080
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] comida,
    output logic [7:0] agua,
    output logic       frame_valid,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic          s1, rs;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bidx, bidx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          stop_ok, stop_bad, start_det;
    logic          idx;
    logic [7:0]    pend;
    logic [GW-1:0] gap;

    // Preset to idle-high so reset release on a quiet line is not a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            rs <= 1'b1;
        end else begin
            s1 <= rx;
            rs <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            bidx  <= bidx_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        bidx_nx   = bidx;
        shreg_nx  = shreg;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        start_det = 1'b0;
        case (state)
            IDLE: begin
                if (!rs) begin
                    state_nx  = START;
                    cnt_nx    = '0;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nx   = '0;
                    bidx_nx  = '0;
                    state_nx = rs ? IDLE : DATA;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nx   = '0;
                    shreg_nx = {rs, shreg[7:1]};
                    bidx_nx  = bidx + 3'd1;
                    if (bidx == 3'd7) state_nx = STOP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            STOP: begin
                // Leave at mid stop bit so a following start edge is caught.
                if (cnt == FULL_M1) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    stop_ok  = rs;
                    stop_bad = ~rs;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comida      <= '0;
            agua        <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            idx         <= 1'b0;
            pend        <= '0;
            gap         <= '0;
        end else begin
            byte_valid  <= stop_ok;
            frame_err   <= stop_bad;
            frame_valid <= 1'b0;
            if (stop_ok) begin
                byte_data <= shreg;
                if (idx) begin
                    comida      <= pend;
                    agua        <= shreg;
                    frame_valid <= 1'b1;
                    idx         <= 1'b0;
                end else begin
                    pend <= shreg;
                    idx  <= 1'b1;
                end
            end else if (stop_bad) begin
                idx <= 1'b0;
            end
            // A half frame left idle too long is dropped silently.
            if (start_det) begin
                gap <= '0;
            end else if (idx && state == IDLE) begin
                if (gap == GAP_END) begin
                    gap <= '0;
                    idx <= 1'b0;
                end else begin
                    gap <= gap + GW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_medidas.sv
// Scoreboard bench for uart_rx_medidas: directed plus random bytes,
// expectations derived from the frame rules and the nominal latency.
module tb_uart_rx_medidas;

    localparam int B   = 104;
    localparam int G   = 2080;
    localparam int LAT = 3 + B / 2 + 9 * B;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] comida, agua, byte_data;
    logic       frame_valid, byte_valid, frame_err, busy;

    uart_rx_medidas #(.BAUD_DIV(B), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .comida(comida), .agua(agua),
        .frame_valid(frame_valid), .byte_valid(byte_valid),
        .byte_data(byte_data), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [7:0] d; int t; } bexp_t;
    typedef struct { logic [7:0] c; logic [7:0] a; int t; } fexp_t;
    bexp_t bq[$];
    fexp_t fq[$];
    int    eq[$];

    bit         have_pend = 0;
    logic [7:0] pend_m = 8'h00;
    logic [7:0] last_c = 8'h00;
    logic [7:0] last_a = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    bexp_t mb;
    fexp_t mf;
    int    me;
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) begin
                if (bq.size() == 0) check("unexpected byte_valid", 1, 0);
                else begin
                    mb = bq.pop_front();
                    check("byte_data", byte_data, mb.d);
                    check("byte_time", cyc, mb.t);
                end
            end
            if (frame_valid) begin
                if (fq.size() == 0) check("unexpected frame_valid", 1, 0);
                else begin
                    mf = fq.pop_front();
                    check("frame_comida", comida, mf.c);
                    check("frame_agua", agua, mf.a);
                    check("frame_time", cyc, mf.t);
                end
            end
            if (frame_err) begin
                if (eq.size() == 0) check("unexpected frame_err", 1, 0);
                else begin
                    me = eq.pop_front();
                    check("err_time", cyc, me);
                end
            end
        end
    end

    // Called at a falling clock edge; returns at one.
    task automatic send_byte(input logic [7:0] d, input bit stop_ok,
                             input int gap);
        int t0;
        bexp_t b;
        fexp_t f;
        if (gap > G) have_pend = 0;
        repeat (gap) @(negedge clk);
        rx = 1'b0;
        t0 = cyc;
        if (stop_ok) begin
            b.d = d;
            b.t = t0 + LAT;
            bq.push_back(b);
            if (have_pend) begin
                f.c = pend_m;
                f.a = d;
                f.t = t0 + LAT;
                fq.push_back(f);
                last_c = pend_m;
                last_a = d;
                have_pend = 0;
            end else begin
                pend_m = d;
                have_pend = 1;
            end
        end else begin
            eq.push_back(t0 + LAT);
            have_pend = 0;
        end
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (B) @(negedge clk);
        end
        rx = stop_ok;
        repeat (B) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] rd;
        bit ok;
        int gp;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_comida", comida, 8'h00);
        check("rst_agua", agua, 8'h00);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_pulses", {byte_valid, frame_valid, frame_err}, 0);
        rst = 1'b0;

        repeat (1000) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_comida", comida, 8'h00);
        check("idle_agua", agua, 8'h00);

        send_byte(8'h3C, 1, 0);
        send_byte(8'h7A, 1, 0);
        repeat (20) @(negedge clk);
        check("b2b_comida", comida, 8'h3C);
        check("b2b_agua", agua, 8'h7A);

        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (25) @(negedge clk);
        check("glitch_busy_low", busy, 0);
        repeat (20) @(negedge clk);

        send_byte(8'h11, 0, 20);
        send_byte(8'h22, 1, 20);
        send_byte(8'h33, 1, 0);
        repeat (20) @(negedge clk);
        check("err_comida", comida, 8'h22);
        check("err_agua", agua, 8'h33);

        send_byte(8'hAA, 1, 20);
        send_byte(8'h05, 1, G + 50);
        send_byte(8'h06, 1, 0);
        repeat (20) @(negedge clk);
        check("gap_comida", comida, 8'h05);
        check("gap_agua", agua, 8'h06);

        send_byte(8'h44, 1, 20);
        repeat (20) @(negedge clk);
        d = 8'h55;
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (B) @(negedge clk);
        end
        rx = d[4];
        repeat (B / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        have_pend = 0;
        last_c = 8'h00;
        last_a = 8'h00;
        repeat (3) @(negedge clk);
        check("mid_rst_comida", comida, 8'h00);
        check("mid_rst_agua", agua, 8'h00);
        check("mid_rst_byte_data", byte_data, 8'h00);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        send_byte(8'h01, 1, 20);
        send_byte(8'h02, 1, 0);
        repeat (20) @(negedge clk);
        check("post_rst_comida", comida, 8'h01);
        check("post_rst_agua", agua, 8'h02);

        for (int n = 0; n < 24; n++) begin
            rd = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            gp = ($urandom_range(0, 7) == 0) ? G + 100
                                             : int'($urandom_range(20, 300));
            send_byte(rd, ok, gp);
        end

        repeat (200) @(negedge clk);
        check("left_bytes", bq.size(), 0);
        check("left_frames", fq.size(), 0);
        check("left_errs", eq.size(), 0);
        check("final_comida", comida, last_c);
        check("final_agua", agua, last_a);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_medidas.md
Name: uart_rx_medidas

Overview:
- Receive end of the sensor-telemetry UART link: deserialises 8N1 bytes from the board's tx line and reassembles the two-byte frame (byte 0 = food/weight, byte 1 = water).
- Presents both values together with a one-cycle frame strobe.
- Sits on the host/monitor FPGA, or in loopback benches, opposite the measurement transmitter.

Parameters:
- BAUD_DIV, 104: clock cycles per bit (115200 baud at 12 MHz); must be >= 8.
- GAP_CYCLES, 2080: idle cycles after byte 0 before a half-received frame is discarded (about 20 bit times).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rx  in  1  serial input; idle high; asynchronous to clk.
- comida  out  8  food/weight byte of the last complete frame.
- agua  out  8  water byte of the last complete frame.
- frame_valid  out  1  one-cycle pulse when comida/agua update.
- byte_valid  out  1  one-cycle pulse per correctly framed byte.
- byte_data  out  8  last correctly framed byte; valid while byte_valid is high and held afterwards.
- frame_err  out  1  one-cycle pulse on stop-bit error.
- busy  out  1  high while the bit FSM is outside IDLE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - comida, agua and byte_data = 0x00.
  - All pulses and busy = 0.
  - Byte index = 0; gap timer = 0.
  - Synchroniser flops preset to 1, so releasing reset on an idle line causes no false start.
- Input path: 2-FF synchroniser; all decisions use its output rs.
- Bit FSM states IDLE, START, DATA, STOP; one bit counter (0..BAUD_DIV-1) and one bit index (0..7).
  - IDLE: when rs=0, go to START and clear the counter.
  - START: at count BAUD_DIV/2-1 (mid start bit), re-sample rs.
    - rs=1: glitch; return to IDLE with no output.
    - rs=0: go to DATA, bit index 0.
  - DATA: sample rs every BAUD_DIV cycles (mid-bit); shift LSB first. After the 8th sample, go to STOP.
  - STOP: sample once BAUD_DIV cycles after the last data sample, then return to IDLE on that same edge. The FSM does not wait for the end of the stop bit, so a start bit immediately following is caught.
    - rs=1: byte good.
    - rs=0: framing error.
- busy = (state != IDLE).
- Good byte: on the edge after the stop sample, byte_valid=1 for one cycle and byte_data = the byte.
  - Index 0: store the byte internally as pending food; index becomes 1.
  - Index 1: comida <= pending, agua <= byte, frame_valid=1 (same cycle as byte_valid); index becomes 0.
- Framing error: frame_err=1 for one cycle; byte dropped; no byte_valid; index forced to 0 (a pending food byte is discarded).
- Gap timeout:
  - The timer runs only while index=1 and FSM=IDLE; it clears on any start detection.
  - When the timer reaches GAP_CYCLES, index is set to 0 silently (no pulse).
- Latency: frame_valid rises exactly 1 clk after the mid-stop-bit sample of byte 1, i.e. about 9.5 bit times plus 3 clk (synchroniser and register) after that byte's start edge.
- comida and agua change only with frame_valid and hold between frames.
- Simultaneous rst and any event: reset wins.
- Reset mid-byte: the partial byte and pending food are lost; reception resumes at the next start edge after rst falls.

Test Plan:
- Idle line 1000 cycles after reset -> busy=0, all pulses 0, comida=agua=0x00.
- Send 0x3C then 0x7A back-to-back, BAUD_DIV=104 -> byte_valid twice with byte_data 0x3C then 0x7A; one frame_valid; comida=0x3C, agua=0x7A; frame_valid exactly 1 clk after the second stop sample.
- Drive rx low for 30 cycles, then high -> START aborts; no pulses; busy back to 0 within 55 cycles.
- Send 0x11 with stop bit=0, then 0x22, 0x33 -> one frame_err pulse; no frame_valid for 0x11; then frame_valid with comida=0x22, agua=0x33.
- Send 0xAA, idle GAP_CYCLES+50, then 0x05, 0x06 -> the 0xAA byte_valid pulses but no frame_valid for 0xAA; final comida=0x05, agua=0x06; exactly one frame_valid.
- Assert rst during bit 4 of byte 1 of a frame (0x44, 0x55), release, then send 0x01, 0x02 -> outputs 0 after reset; one frame_valid, comida=0x01, agua=0x02.
